// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Pipeline sequencer: load-use stalls, branch flushes, memory waits
//            with timeout and interrupt drain/redirect for the 5-stage core.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter logic [1:0] LOAD_WBSEL   = 2'b00,
    parameter int         MEM_TIMEOUT  = 255,
    parameter int         DRAIN_CYCLES = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] inst_d_i,
    input  logic [4:0]  rsW_ex_i,
    input  logic        RegWEn_ex_i,
    input  logic [1:0]  WBSel_ex_i,
    input  logic        br_taken_ex_i,
    input  logic        Valid_cpu2cache_mem_i,
    input  logic        cache_ready_i,
    input  logic        Valid_cpu2aes_mem_i,
    input  logic        aes_ready_i,
    input  logic        intr_flag_i,
    output logic        en_if_o,
    output logic        en_id_o,
    output logic        en_ex_o,
    output logic        en_mem_o,
    output logic        flush_id_o,
    output logic        flush_ex_o,
    output logic        pc_sel_intr_o,
    output logic        mem_timeout_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MEM_WAIT   = 2'd1,
        ST_INTR_DRAIN = 2'd2,
        ST_INTR_REDIR = 2'd3
    } state_t;

    localparam logic [7:0] c_wait_last  = 8'(MEM_TIMEOUT);
    localparam logic [7:0] c_wait_max   = 8'hFF;
    localparam logic [3:0] c_drain_last = 4'(DRAIN_CYCLES);

    state_t     r_state;
    logic [7:0] r_wait_cnt;
    logic [3:0] r_drain_cnt;
    logic       r_mem_timeout;

    logic       w_mem_busy;
    logic       w_load_use;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_en_if;
    logic       w_en_id;
    logic       w_en_ex;
    logic       w_en_mem;
    logic       w_flush_id;
    logic       w_flush_ex;
    logic       w_pc_sel_intr;

    assign w_rs1      = inst_d_i[19:15];
    assign w_rs2      = inst_d_i[24:20];
    assign w_mem_busy = (Valid_cpu2cache_mem_i & ~cache_ready_i) |
                        (Valid_cpu2aes_mem_i   & ~aes_ready_i);
    assign w_load_use = RegWEn_ex_i & (WBSel_ex_i == LOAD_WBSEL) & (rsW_ex_i != 5'd0) &
                        ((rsW_ex_i == w_rs1) | (rsW_ex_i == w_rs2));

    always_comb begin
        w_en_if       = 1'b0;
        w_en_id       = 1'b0;
        w_en_ex       = 1'b0;
        w_en_mem      = 1'b0;
        w_flush_id    = 1'b0;
        w_flush_ex    = 1'b0;
        w_pc_sel_intr = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_mem_busy) begin
                    // everything frozen until the memory access completes
                end else if (intr_flag_i || br_taken_ex_i) begin
                    {w_en_if, w_en_id, w_en_ex, w_en_mem} = 4'b1111;
                    w_flush_id = 1'b1;
                    w_flush_ex = 1'b1;
                end else if (w_load_use) begin
                    // hold IF/ID, let the load advance and bubble EX
                    w_en_ex    = 1'b1;
                    w_en_mem   = 1'b1;
                    w_flush_ex = 1'b1;
                end else begin
                    {w_en_if, w_en_id, w_en_ex, w_en_mem} = 4'b1111;
                end
            end
            ST_MEM_WAIT: begin
                if (!w_mem_busy) begin
                    {w_en_if, w_en_id, w_en_ex, w_en_mem} = 4'b1111;
                end
            end
            ST_INTR_DRAIN: begin
                w_flush_id = 1'b1;
                w_flush_ex = 1'b1;
                if (!w_mem_busy) begin
                    {w_en_if, w_en_id, w_en_ex, w_en_mem} = 4'b1111;
                end
            end
            ST_INTR_REDIR: begin
                {w_en_if, w_en_id, w_en_ex, w_en_mem} = 4'b1111;
                w_flush_id    = 1'b1;
                w_pc_sel_intr = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= 8'd0;
            r_drain_cnt   <= 4'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_mem_timeout <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (w_mem_busy) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= 8'd1;
                    end else if (intr_flag_i) begin
                        r_state     <= ST_INTR_DRAIN;
                        r_drain_cnt <= 4'd1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!w_mem_busy) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= 8'd0;
                    end else if (r_wait_cnt == c_wait_last) begin
                        // forced release so a hung peripheral cannot lock the core
                        r_mem_timeout <= 1'b1;
                        r_state       <= ST_RUN;
                        r_wait_cnt    <= 8'd0;
                    end else if (r_wait_cnt != c_wait_max) begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ST_INTR_DRAIN: begin
                    if (!w_mem_busy) begin
                        if (r_drain_cnt == c_drain_last) begin
                            r_state     <= ST_INTR_REDIR;
                            r_drain_cnt <= 4'd0;
                        end else begin
                            r_drain_cnt <= r_drain_cnt + 4'd1;
                        end
                    end
                end
                ST_INTR_REDIR: begin
                    r_state <= ST_RUN;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // Stage controls are forced low for as long as reset is held
    assign en_if_o       = rst_ni & w_en_if;
    assign en_id_o       = rst_ni & w_en_id;
    assign en_ex_o       = rst_ni & w_en_ex;
    assign en_mem_o      = rst_ni & w_en_mem;
    assign flush_id_o    = rst_ni & w_flush_id;
    assign flush_ex_o    = rst_ni & w_flush_ex;
    assign pc_sel_intr_o = rst_ni & w_pc_sel_intr;
    assign mem_timeout_o = r_mem_timeout;
    assign state_o       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed self-checking bench for pipe_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] inst_d_i = 32'd0;
    logic [4:0]  rsW_ex_i = 5'd0;
    logic        RegWEn_ex_i = 1'b0;
    logic [1:0]  WBSel_ex_i = 2'b01;
    logic        br_taken_ex_i = 1'b0;
    logic        Valid_cpu2cache_mem_i = 1'b0;
    logic        cache_ready_i = 1'b0;
    logic        Valid_cpu2aes_mem_i = 1'b0;
    logic        aes_ready_i = 1'b0;
    logic        intr_flag_i = 1'b0;
    logic        en_if_o, en_id_o, en_ex_o, en_mem_o;
    logic        flush_id_o, flush_ex_o, pc_sel_intr_o, mem_timeout_o;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .inst_d_i              (inst_d_i),
        .rsW_ex_i              (rsW_ex_i),
        .RegWEn_ex_i           (RegWEn_ex_i),
        .WBSel_ex_i            (WBSel_ex_i),
        .br_taken_ex_i         (br_taken_ex_i),
        .Valid_cpu2cache_mem_i (Valid_cpu2cache_mem_i),
        .cache_ready_i         (cache_ready_i),
        .Valid_cpu2aes_mem_i   (Valid_cpu2aes_mem_i),
        .aes_ready_i           (aes_ready_i),
        .intr_flag_i           (intr_flag_i),
        .en_if_o               (en_if_o),
        .en_id_o               (en_id_o),
        .en_ex_o               (en_ex_o),
        .en_mem_o              (en_mem_o),
        .flush_id_o            (flush_id_o),
        .flush_ex_o            (flush_ex_o),
        .pc_sel_intr_o         (pc_sel_intr_o),
        .mem_timeout_o         (mem_timeout_o),
        .state_o               (state_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected vector layout: {state[1:0], en_if, en_id, en_ex, en_mem, flush_id, flush_ex, pc_sel}
    task automatic chk(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {state_o, en_if_o, en_id_o, en_ex_o, en_mem_o, flush_id_o, flush_ex_o, pc_sel_intr_o};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] mk_inst(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, 5'd6, 7'h33};
    endfunction

    int pulses;
    int pulse_cyc;
    int pulse_state;

    initial begin
        // Reset state
        #2;
        chk("reset_outputs", 9'b00_0000000);
        chk_int("reset_timeout", int'(mem_timeout_o), 0);
        step();
        rst_ni = 1'b1;
        #1;
        chk("idle_run", 9'b00_1111000);

        // Load-use on rs1: lw x5 in EX, add x6,x5,x1 in decode
        inst_d_i = mk_inst(5'd5, 5'd1);
        rsW_ex_i = 5'd5; RegWEn_ex_i = 1'b1; WBSel_ex_i = 2'b00;
        #1 chk("loaduse_rs1", 9'b00_0011010);
        step();
        RegWEn_ex_i = 1'b0; rsW_ex_i = 5'd0;
        #1 chk("after_loaduse", 9'b00_1111000);
        step();

        // Load-use on rs2
        rsW_ex_i = 5'd1; RegWEn_ex_i = 1'b1;
        #1 chk("loaduse_rs2", 9'b00_0011010);
        // Non-load writeback to the same register does not stall
        WBSel_ex_i = 2'b01; rsW_ex_i = 5'd5;
        #1 chk("alu_no_stall", 9'b00_1111000);
        // Load to x0 with decode reading x0
        WBSel_ex_i = 2'b00; rsW_ex_i = 5'd0; inst_d_i = mk_inst(5'd0, 5'd0);
        #1 chk("load_x0", 9'b00_1111000);
        step();

        // Branch together with load-use: branch wins
        inst_d_i = mk_inst(5'd5, 5'd1); rsW_ex_i = 5'd5;
        br_taken_ex_i = 1'b1;
        #1 chk("branch_over_loaduse", 9'b00_1111110);
        step();
        br_taken_ex_i = 1'b0; RegWEn_ex_i = 1'b0;
        #1 chk("after_branch", 9'b00_1111000);
        step();

        // Cache not ready for 4 cycles
        Valid_cpu2cache_mem_i = 1'b1; cache_ready_i = 1'b0;
        #1 chk("cache_wait0", 9'b00_0000000);
        for (int i = 1; i < 4; i++) begin
            step();
            chk($sformatf("cache_wait%0d", i), 9'b01_0000000);
        end
        step();
        cache_ready_i = 1'b1;
        #1 chk("cache_release", 9'b01_1111000);
        step();
        Valid_cpu2cache_mem_i = 1'b0; cache_ready_i = 1'b0;
        #1 chk("cache_back_run", 9'b00_1111000);
        chk_int("cache_no_timeout", int'(mem_timeout_o), 0);
        step();

        // Interrupt entry, with branch/load-use ignored while draining
        intr_flag_i = 1'b1;
        #1 chk("intr_entry", 9'b00_1111110);
        step();
        intr_flag_i = 1'b0;
        #1 chk("intr_drain1", 9'b10_1111110);
        step();
        br_taken_ex_i = 1'b1; RegWEn_ex_i = 1'b1;
        #1 chk("intr_drain2_ignore", 9'b10_1111110);
        step();
        br_taken_ex_i = 1'b0; RegWEn_ex_i = 1'b0;
        #1 chk("intr_drain3", 9'b10_1111110);
        step();
        chk("intr_redir", 9'b11_1111101);
        step();
        chk("intr_done", 9'b00_1111000);
        step();

        // Memory stall during drain freezes enables and the drain count
        intr_flag_i = 1'b1;
        #1 chk("intr2_entry", 9'b00_1111110);
        step();
        intr_flag_i = 1'b0; Valid_cpu2cache_mem_i = 1'b1;
        #1 chk("drain_busy_a", 9'b10_0000110);
        step();
        chk("drain_busy_b", 9'b10_0000110);
        Valid_cpu2cache_mem_i = 1'b0;
        #1 chk("drain_resume1", 9'b10_1111110);
        step();
        chk("drain_resume2", 9'b10_1111110);
        step();
        chk("drain_resume3", 9'b10_1111110);
        step();
        chk("drain_redir", 9'b11_1111101);
        step();

        // AES never ready: single timeout pulse after 255 wait cycles
        Valid_cpu2aes_mem_i = 1'b1; aes_ready_i = 1'b0;
        #1 chk("aes_wait0", 9'b00_0000000);
        pulses = 0; pulse_cyc = -1; pulse_state = -1;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (mem_timeout_o === 1'b1) begin
                pulses++;
                pulse_cyc   = i;
                pulse_state = int'(state_o);
            end
        end
        chk_int("timeout_pulse_count", pulses, 1);
        chk_int("timeout_pulse_cycle", pulse_cyc, 256);
        chk_int("timeout_state", pulse_state, 0);
        Valid_cpu2aes_mem_i = 1'b0;
        step();
        step();
        chk("after_timeout", 9'b00_1111000);

        // Asynchronous reset in MEM_WAIT
        Valid_cpu2cache_mem_i = 1'b1;
        step();
        step();
        step();
        chk("pre_reset_wait", 9'b01_0000000);
        rst_ni = 1'b0;
        #1 chk("async_reset", 9'b00_0000000);
        chk_int("async_reset_timeout", int'(mem_timeout_o), 0);
        Valid_cpu2cache_mem_i = 1'b0;
        step();
        rst_ni = 1'b1;
        #1 chk("post_reset_run", 9'b00_1111000);
        step();
        chk_int("post_reset_timeout", int'(mem_timeout_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
